// File: rtl/dma_reg_arbiter.sv
// -----------------------------------------------------------------------------
// dma_reg_arbiter
//
// Shares the DMA register-block bus between two requesters (port 0: host
// sequencer, port 1: descriptor-fetch engine). One command is in flight at a
// time. A command is accepted with a one-cycle gnt pulse while the FSM is
// idle. Ties are broken round-robin. The captured command is then driven to
// the register block as a registered single-cycle wr_en/rd_en strobe. For a
// read, rdata is sampled RD_LATENCY cycles after the rd_en cycle and returned
// to the owning port with a one-cycle rvalid pulse.
//
// Parameters
//   DATA_WIDTH  data bus width
//   ADDR_WIDTH  address bus width
//   RD_LATENCY  cycles from the rd_en cycle to valid rdata (1..7)
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   mN_req/we/addr/wdata        port N command (held until mN_gnt)
//   mN_gnt                      combinational command-accept pulse
//   mN_rvalid/mN_rdata          registered read return (rdata held afterwards)
//   wr_en/rd_en/addr/wdata      registered register-block command
//   rdata                       register-block read data
// -----------------------------------------------------------------------------
module dma_reg_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    state_t                state_reg, state_next;
    logic [2:0]            cnt_reg, cnt_next;
    // 1 = port 1 was granted most recently, so port 0 wins the next tie.
    logic                  last_reg, last_next;
    logic                  we_reg, we_next;
    logic                  owner_reg, owner_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  wr_en_reg, wr_en_next;
    logic                  rd_en_reg, rd_en_next;
    logic                  rd_done;

    logic                  idle;
    logic                  win;
    logic [1:0]            gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [1:0]            rvalid_w;
    logic [DATA_WIDTH-1:0] rdata_w [2];

    // Grants are withheld during reset so a requester never sees a gnt for a
    // command that the reset is about to discard.
    assign idle   = (state_reg == IDLE) && !rst;
    assign gnt[0] = idle && m0_req && (!m1_req || last_reg);
    assign gnt[1] = idle && m1_req && (!m0_req || !last_reg);
    assign win    = gnt[1];

    assign sel_we    = win ? m1_we    : m0_we;
    assign sel_addr  = win ? m1_addr  : m0_addr;
    assign sel_wdata = win ? m1_wdata : m0_wdata;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        last_next  = last_reg;
        we_next    = we_reg;
        owner_next = owner_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wr_en_next = 1'b0;
        rd_en_next = 1'b0;
        rd_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|gnt) begin
                    state_next = ISSUE;
                    last_next  = win;
                    owner_next = win;
                    we_next    = sel_we;
                    addr_next  = sel_addr;
                    // wdata keeps the last written value across reads.
                    if (sel_we) begin
                        wdata_next = sel_wdata;
                    end
                    // Strobes are registered, so they are set here and appear
                    // in the ISSUE cycle.
                    wr_en_next = sel_we;
                    rd_en_next = !sel_we;
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    state_next = IDLE;
                end else begin
                    state_next = RDWAIT;
                    cnt_next   = 3'(RD_LATENCY - 1);
                end
            end
            RDWAIT: begin
                if (cnt_reg == 3'd0) begin
                    state_next = IDLE;
                    rd_done    = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            last_reg  <= 1'b1;
            we_reg    <= 1'b0;
            owner_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wr_en_reg <= 1'b0;
            rd_en_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
            we_reg    <= we_next;
            owner_reg <= owner_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wr_en_reg <= wr_en_next;
            rd_en_reg <= rd_en_next;
        end
    end

    // Per-port read return: only the owner of the finishing read updates.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_port
            logic                  rvalid_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic                  hit;

            assign hit = rd_done && (owner_reg == 1'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= hit;
                    if (hit) begin
                        rdata_reg <= rdata;
                    end
                end
            end

            assign rvalid_w[gi] = rvalid_reg;
            assign rdata_w[gi]  = rdata_reg;
        end
    endgenerate

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid_w[0];
    assign m1_rvalid = rvalid_w[1];
    assign m0_rdata  = rdata_w[0];
    assign m1_rdata  = rdata_w[1];
    assign wr_en     = wr_en_reg;
    assign rd_en     = rd_en_reg;
    assign addr      = addr_reg;
    assign wdata     = wdata_reg;

endmodule

// File: tb/tb_dma_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_reg_arbiter
//
// Directed bench. "dut" uses RD_LATENCY=1 and sits on a small register-file
// model that returns read data one cycle after rd_en. "dut3" uses
// RD_LATENCY=3 and sees rdata that changes every cycle, so the captured value
// identifies the sampling cycle.
// -----------------------------------------------------------------------------
module tb_dma_reg_arbiter;

    logic        clk;
    logic        rst;
    int          total;
    int          bad;
    int          cyc;
    int          t0;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        wr_en, rd_en;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata_m;
    logic [31:0] mem [256];

    logic        p3_req, p3_we;
    logic [7:0]  p3_addr;
    logic        m0_gnt3, m1_gnt3, m0_rvalid3, m1_rvalid3;
    logic [31:0] m0_rdata3, m1_rdata3;
    logic        wr_en3, rd_en3;
    logic [7:0]  addr3;
    logic [31:0] wdata3, rdata3;

    assign rdata3 = 32'hC0DE_0000 + cyc;

    dma_reg_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata_m)
    );

    dma_reg_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .m0_req(p3_req), .m0_we(p3_we), .m0_addr(p3_addr), .m0_wdata(32'h0),
        .m0_gnt(m0_gnt3), .m0_rvalid(m0_rvalid3), .m0_rdata(m0_rdata3),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(8'h0), .m1_wdata(32'h0),
        .m1_gnt(m1_gnt3), .m1_rvalid(m1_rvalid3), .m1_rdata(m1_rdata3),
        .wr_en(wr_en3), .rd_en(rd_en3), .addr(addr3), .wdata(wdata3), .rdata(rdata3)
    );

    // Register-block model: one-cycle read latency.
    always @(posedge clk) begin
        if (wr_en) mem[addr] <= wdata;
        if (rd_en) rdata_m <= mem[addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; t0 = 0;
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h0; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h0; m1_wdata = 32'h0;
        p3_req = 1'b1; p3_we = 1'b0; p3_addr = 8'h0;

        // Reset state, with requests asserted to show gnt is held off.
        tick(); tick(); #1;
        chk("rst_m0_gnt", 64'(m0_gnt), 64'd0);
        chk("rst_m1_gnt", 64'(m1_gnt), 64'd0);
        chk("rst_gnt3", 64'(m0_gnt3), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
        chk("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'd0);
        m0_req = 1'b0; m1_req = 1'b0; p3_req = 1'b0;
        rst = 1'b0;
        tick();

        // Port 0 write 0x10 <- DEADBEEF.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h10; m0_wdata = 32'hDEADBEEF; #1;
        chk("w0_m0_gnt", 64'(m0_gnt), 64'd1);
        chk("w0_m1_gnt", 64'(m1_gnt), 64'd0);
        tick(); m0_req = 1'b0; #1;
        chk("w0_wr_en", 64'(wr_en), 64'd1);
        chk("w0_rd_en", 64'(rd_en), 64'd0);
        chk("w0_addr", 64'(addr), 64'h10);
        chk("w0_wdata", 64'(wdata), 64'hDEADBEEF);
        chk("w0_gnt_issue", 64'(m0_gnt), 64'd0);
        tick(); #1;
        chk("w0_wr_en_off", 64'(wr_en), 64'd0);
        chk("w0_addr_hold", 64'(addr), 64'h10);

        // Port 1 read 0x10, data back at T+3.
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h10; #1;
        chk("r1_m1_gnt", 64'(m1_gnt), 64'd1);
        tick(); m1_req = 1'b0; #1;
        chk("r1_rd_en", 64'(rd_en), 64'd1);
        chk("r1_wr_en", 64'(wr_en), 64'd0);
        tick(); #1;
        chk("r1_rd_en_off", 64'(rd_en), 64'd0);
        chk("r1_rvalid_early", 64'(m1_rvalid), 64'd0);
        tick(); #1;
        chk("r1_rvalid", 64'(m1_rvalid), 64'd1);
        chk("r1_rdata", 64'(m1_rdata), 64'hDEADBEEF);
        chk("r1_m0_rvalid", 64'(m0_rvalid), 64'd0);
        tick(); #1;
        chk("r1_rvalid_off", 64'(m1_rvalid), 64'd0);
        chk("r1_rdata_hold", 64'(m1_rdata), 64'hDEADBEEF);

        // Both ports write continuously: grants alternate 0,1,0,1.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h20;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h30;
        for (int i = 0; i < 4; i++) begin
            m0_wdata = 32'h1000 + i; m1_wdata = 32'h2000 + i; #1;
            chk($sformatf("rr%0d_m0_gnt", i), 64'(m0_gnt), 64'((i % 2) == 0));
            chk($sformatf("rr%0d_m1_gnt", i), 64'(m1_gnt), 64'((i % 2) == 1));
            tick(); #1;
            chk($sformatf("rr%0d_wr_en", i), 64'(wr_en), 64'd1);
            chk($sformatf("rr%0d_addr", i), 64'(addr), (i % 2) ? 64'h30 : 64'h20);
            chk($sformatf("rr%0d_wdata", i), 64'(wdata),
                (i % 2) ? 64'(32'h2000 + i) : 64'(32'h1000 + i));
            chk($sformatf("rr%0d_no_gnt", i), 64'({m0_gnt, m1_gnt}), 64'd0);
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // RD_LATENCY=3 instance: value present 3 cycles after rd_en is captured.
        p3_req = 1'b1; p3_we = 1'b0; p3_addr = 8'h44; #1;
        chk("l3_gnt", 64'(m0_gnt3), 64'd1);
        t0 = cyc;
        tick(); p3_req = 1'b0; #1;
        chk("l3_rd_en", 64'(rd_en3), 64'd1);
        for (int k = 2; k <= 4; k++) begin
            tick(); #1;
            chk($sformatf("l3_rvalid_t%0d", k), 64'(m0_rvalid3), 64'd0);
        end
        tick(); #1;
        chk("l3_rvalid", 64'(m0_rvalid3), 64'd1);
        chk("l3_rdata", 64'(m0_rdata3), 64'(32'hC0DE_0000 + t0 + 4));
        tick(); #1;
        chk("l3_rvalid_off", 64'(m0_rvalid3), 64'd0);

        // Reset the cycle after rd_en: read abandoned, port 0 wins next tie.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10; #1;
        chk("rr_m0_gnt", 64'(m0_gnt), 64'd1);
        tick(); m0_req = 1'b0; #1;
        chk("rr_rd_en", 64'(rd_en), 64'd1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; #1;
        chk("rr_wr_rd", 64'({wr_en, rd_en}), 64'd0);
        chk("rr_addr", 64'(addr), 64'd0);
        chk("rr_wdata", 64'(wdata), 64'd0);
        chk("rr_m1_rdata", 64'(m1_rdata), 64'd0);
        chk("rr_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            chk($sformatf("rr_no_rvalid%0d", k), 64'(m0_rvalid), 64'd0);
        end
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h20; m0_wdata = 32'h1111;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h50; m1_wdata = 32'h2222; #1;
        chk("rr_tie_m0", 64'(m0_gnt), 64'd1);
        chk("rr_tie_m1", 64'(m1_gnt), 64'd0);
        tick(); m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // Port 1 waits while port 0 reads; its gnt coincides with m0_rvalid.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h30; #1;
        chk("hw_m0_gnt", 64'(m0_gnt), 64'd1);
        tick(); m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h40; m1_wdata = 32'h55; #1;
        chk("hw_m1_wait_issue", 64'(m1_gnt), 64'd0);
        chk("hw_rd_en", 64'(rd_en), 64'd1);
        tick(); #1;
        chk("hw_m1_wait_rdwait", 64'(m1_gnt), 64'd0);
        tick(); #1;
        chk("hw_m0_rvalid", 64'(m0_rvalid), 64'd1);
        chk("hw_m0_rdata", 64'(m0_rdata), 64'h2003);
        chk("hw_m1_gnt", 64'(m1_gnt), 64'd1);
        tick(); m1_req = 1'b0; #1;
        chk("hw_wr_en", 64'(wr_en), 64'd1);
        chk("hw_addr", 64'(addr), 64'h40);
        chk("hw_wdata", 64'(wdata), 64'h55);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_reg_arbiter.md
# dma_reg_arbiter

Two-port arbiter sharing the DMA register-block bus (wr_en, rd_en, wdata, addr, rdata) between two requesters, e.g. the host sequencer (port 0) and the descriptor-fetch engine (port 1). It accepts one command at a time through a req/gnt handshake, grants by round-robin, and drives registered single-cycle strobes to the register block. Read data returns to the owning requester with an rvalid pulse.

## Interface
- DATA_WIDTH, 32 (matches `DATA_WIDTH`), data bus width
- ADDR_WIDTH, 8 (matches `ADDR_WIDTH`), address bus width
- RD_LATENCY, 1, cycles from the rd_en cycle to valid rdata; legal range 1..7
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- mN_req  in  1  port N (N=0,1) command request; held with fields until mN_gnt
- mN_we  in  1  1 = write, 0 = read
- mN_addr  in  ADDR_WIDTH  command address
- mN_wdata  in  DATA_WIDTH  write data (ignored for reads)
- mN_gnt  out  1  combinational one-cycle command-accept pulse
- mN_rvalid  out  1  registered one-cycle read-data-valid pulse
- mN_rdata  out  DATA_WIDTH  read data, valid with mN_rvalid, held afterwards
- wr_en  out  1  register-block write strobe
- rd_en  out  1  register-block read strobe
- addr  out  ADDR_WIDTH  register-block address
- wdata  out  DATA_WIDTH  register-block write data
- rdata  in  DATA_WIDTH  register-block read data

## Operation
- FSM states: IDLE, ISSUE, RDWAIT.
- IDLE: when any mN_req=1, select the winner, assert its mN_gnt, capture we/addr/wdata/owner into registers, go to ISSUE. With no request, stay in IDLE.
- Arbitration: with a single requester, that requester wins. When both request, the port not granted most recently wins. The last-grant pointer updates only on a grant. Reset sets the pointer so port 0 wins the first tie.
- ISSUE: drive the captured command for exactly one cycle: wr_en=we, rd_en=!we. wr_en and rd_en are never both 1. A write returns to IDLE. A read goes to RDWAIT with the counter loaded to RD_LATENCY-1.
- RDWAIT: hold for RD_LATENCY cycles. In the final cycle (counter=0), sample rdata into the owner's mN_rdata, set the owner's mN_rvalid for the next cycle, and return to IDLE.
- addr and wdata are registered and hold their last value while idle. wdata updates only on writes.
- No gnt is issued outside IDLE. Requests arriving during ISSUE or RDWAIT wait.
- Reset, outputs: wr_en=rd_en=0, addr=0, wdata=0, mN_gnt=0, mN_rvalid=0, mN_rdata=0.
- Reset, internal state: FSM in IDLE, counter=0.
- Reset mid-operation: the in-flight transaction is abandoned with no rvalid. A requester that was already granted must reissue.

## Timing
- Grant in cycle T leads to a strobe in T+1.
- Write: back in IDLE at T+2, so the next gnt can occur at T+2. Sustained writes run at 2 cycles per transaction.
- Read: rdata is sampled at T+1+RD_LATENCY and mN_rvalid is high at T+2+RD_LATENCY. The FSM is in IDLE that same cycle, so a new gnt can coincide with rvalid.
- Read turnaround is 2+RD_LATENCY cycles (3 with the default).
- mN_gnt depends combinationally on mN_req, the FSM state and the pointer. All other outputs are registered.

## Test plan
- Port 0 write, addr=0x10, wdata=0xDEADBEEF -> m0_gnt at T; wr_en=1, addr=0x10, wdata=0xDEADBEEF at T+1 only; rd_en stays 0.
- Port 1 read, addr=0x10, with the register block returning 0xDEADBEEF one cycle after rd_en -> rd_en at T+1; m1_rvalid=1 with m1_rdata=0xDEADBEEF at T+3 only; m0_rvalid stays 0.
- Both ports request writes continuously from reset -> grants alternate m0, m1, m0, m1 every 2 cycles. No port is granted twice in a row while the other is waiting.
- Port 0 read with RD_LATENCY=3 and rdata changing every cycle -> the value present 3 cycles after rd_en is captured; m0_rvalid appears 5 cycles after gnt.
- rst asserted the cycle after rd_en -> next cycle: all outputs 0, FSM in IDLE, no rvalid ever appears. The following tie is granted to port 0.
- Port 1 holds req with no change while port 0 reads -> m1_gnt occurs the same cycle as m0_rvalid, never earlier.
